// File: rtl/sound_pkg.sv
// Shared constants for the melody sequencer: note codes, tone half-period table, FSM states.
package sound_pkg;

  localparam int unsigned HP_W = 18;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_END  = 4'd15;

  // Half-periods in clk cycles at 100 MHz; entry 0 is C4 (code 1), entry 7 is C5 (code 8).
  localparam logic [7:0][HP_W-1:0] HALF_PERIOD = {
    18'd95556, 18'd101239, 18'd113636, 18'd127551,
    18'd143172, 18'd151685, 18'd170265, 18'd191110
  };

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StDone
  } state_e;

  // Codes 1..8 are pitched notes; everything else is silent.
  function automatic logic is_tone(input logic [3:0] code);
    return (code != NOTE_REST) && (code <= 4'd8);
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: toggles audio every hp cycles while enabled, silent and cleared otherwise.
module tone_gen
  import sound_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [HP_W-1:0] hp,
  input  logic            en,
  input  logic            clr,
  output logic            audio
);

  logic [HP_W-1:0] cnt_q, cnt_d;
  logic            audio_q, audio_d;

  always_comb begin
    cnt_d   = cnt_q;
    audio_d = audio_q;
    if (clr || !en) begin
      cnt_d   = '0;
      audio_d = 1'b0;
    end else if (cnt_q == hp - HP_W'(1)) begin
      cnt_d   = '0;
      audio_d = ~audio_q;
    end else begin
      cnt_d = cnt_q + HP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      audio_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      audio_q <= audio_d;
    end
  end

  assign audio = audio_q;

endmodule

// File: rtl/sound_sequencer.sv
// Beat-driven 16-step melody player with two selectable ROM melodies and a square-wave output.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int unsigned HP_SHIFT = 0,
  parameter bit          LOOP     = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tempo,
  input  logic       start,
  input  logic       stop,
  input  logic       sel,
  output logic       audio,
  output logic       busy,
  output logic [3:0] note_idx,
  output logic       done
);

  // Melody ROM, step 0 in the low nibble. Melody 0 ends with a marker at step 4.
  localparam logic [15:0][3:0] MELODY0 = 64'h0000_0000_000F_4321;
  localparam logic [15:0][3:0] MELODY1 = 64'h2345_6780_8765_4321;
  localparam logic [1:0][15:0][3:0] MELODY = {MELODY1, MELODY0};

  state_e          state_q, state_d;
  logic            tempo_q, beat;
  logic            sel_q, sel_d;
  logic [3:0]      note_idx_q, note_idx_d, next_idx;
  logic [3:0]      code, next_code;
  logic            busy_q, busy_d, done_q, done_d;
  logic            end_hit;
  logic [2:0]      hp_sel;
  logic [HP_W-1:0] hp;
  logic            tone_en, tone_clr;

  assign beat      = tempo ^ tempo_q;
  assign next_idx  = note_idx_q + 4'd1;
  assign code      = MELODY[sel_q][note_idx_q];
  assign next_code = MELODY[sel_q][next_idx];
  assign end_hit   = (note_idx_q == 4'd15) || (next_code == NOTE_END);

  // Code 8 wraps to index 7 (C5), codes 1..7 map to 0..6.
  assign hp_sel   = code[2:0] - 3'd1;
  assign hp       = HALF_PERIOD[hp_sel] >> HP_SHIFT;
  assign tone_en  = (state_q == StPlay) && is_tone(code);
  // Any beat in PLAY changes the note (or ends playback), so restart the tone cleanly.
  assign tone_clr = (state_q != StPlay) || stop || beat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start && !stop) state_d = StPlay;
      StPlay: begin
        if (stop) begin
          state_d = StIdle;
        end else if (beat && end_hit && !LOOP) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sel_d      = sel_q;
    note_idx_d = note_idx_q;
    unique case (state_q)
      StIdle: begin
        note_idx_d = 4'd0;
        if (start && !stop) sel_d = sel;
      end
      StPlay: begin
        if (stop) begin
          note_idx_d = 4'd0;
        end else if (beat) begin
          if (!end_hit) begin
            note_idx_d = next_idx;
          end else if (LOOP) begin
            note_idx_d = 4'd0;
          end
        end
      end
      StDone:  note_idx_d = 4'd0;
      default: note_idx_d = 4'd0;
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tempo_q    <= 1'b0;
      sel_q      <= 1'b0;
      note_idx_q <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tempo_q    <= tempo;
      sel_q      <= sel_d;
      note_idx_q <= note_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  tone_gen u_tone_gen (
    .clk   (clk),
    .rst   (rst),
    .hp    (hp),
    .en    (tone_en),
    .clr   (tone_clr),
    .audio (audio)
  );

  assign busy     = busy_q;
  assign note_idx = note_idx_q;
  assign done     = done_q;

endmodule
